// File: rtl/serial_subtractor_2b.sv
// Multi-cycle subtractor: diff = a - b - bin, two result bits per clock
// through one 2-bit borrow slice, with start/busy/done handshake and flags.
module serial_subtractor_2b #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             zero,
    output logic             ovf
);

    localparam int N  = WIDTH / 2;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             br_q, br_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;

    logic [1:0] sa, sb;
    logic       d0, d1, br1, br2, last;

    always_comb begin
        sa   = a_q[2*cnt_q +: 2];
        sb   = b_q[2*cnt_q +: 2];
        d0   = sa[0] ^ sb[0] ^ br_q;
        br1  = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br_q);
        d1   = sa[1] ^ sb[1] ^ br1;
        br2  = (~sa[1] & sb[1]) | (~(sa[1] ^ sb[1]) & br1);
        last = (cnt_q == CW'(N - 1));
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        br_d    = br_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
        zero_d  = zero_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    br_d    = bin;
                    cnt_d   = '0;
                    res_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                res_d[2*cnt_q +: 2] = {d1, d0};
                br_d  = br2;
                cnt_d = cnt_q + CW'(1);
                // Final slice: br1 is the borrow into the MSB, br2 the borrow out.
                if (last) begin
                    state_d = DONE;
                    diff_d  = res_d;
                    bout_d  = br2;
                    zero_d  = (res_d == '0);
                    ovf_d   = br1 ^ br2;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            br_q    <= 1'b0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            br_q    <= br_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
            zero_q  <= zero_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign diff = diff_q;
    assign bout = bout_q;
    assign zero = zero_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_subtractor_2b.sv
// Directed-vector bench for serial_subtractor_2b at WIDTH=8.
// Expected values are hand-computed constants.
module tb_serial_subtractor_2b;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] a, b;
    logic       bin;
    logic       busy, done;
    logic [7:0] diff;
    logic       bout, zero, ovf;

    int nvec;
    int nerr;

    serial_subtractor_2b #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout),
        .zero  (zero),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(input string tag, input logic [7:0] av,
                         input logic [7:0] bv, input logic bv_in,
                         input logic [7:0] ed, input logic eb,
                         input logic ez, input logic eo);
        @(negedge clk);
        a = av; b = bv; bin = bv_in; start = 1'b1;
        tick();
        chk({tag, ".busy0"}, 32'(busy), 1);
        chk({tag, ".done0"}, 32'(done), 0);
        @(negedge clk);
        start = 1'b0;
        for (int i = 1; i < 4; i++) begin
            tick();
            chk({tag, ".busyrun"}, 32'(busy), 1);
            chk({tag, ".donerun"}, 32'(done), 0);
        end
        tick();
        chk({tag, ".done"}, 32'(done), 1);
        chk({tag, ".busyd"}, 32'(busy), 0);
        chk({tag, ".diff"}, 32'(diff), 32'(ed));
        chk({tag, ".bout"}, 32'(bout), 32'(eb));
        chk({tag, ".zero"}, 32'(zero), 32'(ez));
        chk({tag, ".ovf"}, 32'(ovf), 32'(eo));
        tick();
        chk({tag, ".idle"}, 32'(done), 0);
        chk({tag, ".hold"}, 32'(diff), 32'(ed));
    endtask

    initial begin
        int ndone;
        nvec = 0;
        nerr = 0;
        rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        tick();
        tick();
        chk("rst.busy", 32'(busy), 0);
        chk("rst.done", 32'(done), 0);
        chk("rst.diff", 32'(diff), 0);
        chk("rst.flags", 32'({bout, zero, ovf}), 0);
        @(negedge clk);
        rst = 1'b0;

        do_op("v5a23", 8'h5A, 8'h23, 1'b0, 8'h37, 1'b0, 1'b0, 1'b0);
        do_op("v1020", 8'h10, 8'h20, 1'b0, 8'hF0, 1'b1, 1'b0, 1'b0);
        do_op("v8001", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b0, 1'b1);
        do_op("v7fff", 8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b0, 1'b1);
        do_op("v3332", 8'h33, 8'h32, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0);
        do_op("v0000", 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0);

        // start during RUN is ignored; start in DONE chains the next op
        @(negedge clk);
        a = 8'h5A; b = 8'h23; bin = 1'b0; start = 1'b1;
        tick();
        @(negedge clk);
        start = 1'b0;
        tick();
        @(negedge clk);
        a = 8'hFF; b = 8'h00; start = 1'b1;
        tick();
        chk("ign.busy", 32'(busy), 1);
        @(negedge clk);
        start = 1'b0;
        tick();
        tick();
        chk("ign.done", 32'(done), 1);
        chk("ign.diff", 32'(diff), 32'h37);
        @(negedge clk);
        a = 8'h09; b = 8'h04; start = 1'b1;
        tick();
        chk("b2b.busy", 32'(busy), 1);
        chk("b2b.done", 32'(done), 0);
        chk("b2b.hold", 32'(diff), 32'h37);
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("b2b.holdrun", 32'(diff), 32'h37);
        end
        tick();
        chk("b2b.done2", 32'(done), 1);
        chk("b2b.diff2", 32'(diff), 32'h05);
        tick();

        // reset mid-run aborts with no done pulse
        @(negedge clk);
        a = 8'h5A; b = 8'h23; bin = 1'b0; start = 1'b1;
        tick();
        @(negedge clk);
        start = 1'b0;
        tick();
        @(negedge clk);
        rst = 1'b1;
        tick();
        chk("abort.busy", 32'(busy), 0);
        chk("abort.done", 32'(done), 0);
        chk("abort.diff", 32'(diff), 0);
        chk("abort.flags", 32'({bout, zero, ovf}), 0);
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (done) ndone++;
        end
        chk("abort.nodone", 32'(ndone), 0);
        do_op("fresh", 8'h5A, 8'h23, 1'b0, 8'h37, 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
